// File: rtl/central_ctrl.sv
// Instruction sequencer: optional operand fetch, arithmetic start/finish handshake
// with a WAIT watchdog, completion pulse and a wrapping completed-instruction count.
//
// state | meaning
// IDLE  | waiting for go with a non-null opcode
// MEM   | operand read requested, waiting for mem_ack
// LOAD  | one-cycle load of memory data into the datapath
// START | one-cycle start pulse to the arithmetic controller
// WAIT  | waiting for arith_finish, watchdog counting
// DONE  | one-cycle completion pulse
// ERR   | watchdog expired, held until abort or reset
module central_ctrl #(
   parameter int WDOG_LIMIT = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             go,
   input  logic [2:0]       instr_op,
   input  logic             instr_fetch,
   input  logic             abort,
   output logic             mem_req,
   input  logic             mem_ack,
   output logic             do_read_mem,
   output logic             arith_start,
   output logic [2:0]       arith_op,
   input  logic             arith_finish,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_NULL = 3'd0;
   localparam logic [7:0] WDOG_TC = 8'(WDOG_LIMIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MEM   = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t           state_q;
   logic [2:0]       arith_op_q;
   logic [CNT_W-1:0] op_count_q;
   logic [7:0]       wdog_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         arith_op_q <= 3'd0;
         op_count_q <= '0;
         wdog_q     <= 8'd0;
      end else if (abort) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (go && (instr_op != OP_NULL)) begin
                  arith_op_q <= instr_op;
                  state_q    <= instr_fetch ? S_MEM : S_START;
               end
            end
            S_MEM: begin
               if (mem_ack) state_q <= S_LOAD;
            end
            S_LOAD: begin
               state_q <= S_START;
            end
            S_START: begin
               wdog_q  <= 8'd0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Finish beats the watchdog when both land in the same cycle;
               // the count moves on entry to DONE so it is visible with the pulse.
               if (arith_finish) begin
                  op_count_q <= op_count_q + CNT_W'(1);
                  state_q    <= S_DONE;
               end else if (wdog_q == WDOG_TC) begin
                  state_q <= S_ERR;
               end else begin
                  wdog_q <= wdog_q + 8'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req     = (state_q == S_MEM);
   assign do_read_mem = (state_q == S_LOAD);
   assign arith_start = (state_q == S_START);
   assign done        = (state_q == S_DONE);
   assign err         = (state_q == S_ERR);
   assign busy        = (state_q != S_IDLE);
   assign arith_op    = arith_op_q;
   assign op_count    = op_count_q;

endmodule

// File: doc/central_ctrl.md
CENTRAL_CTRL -- requirements
Module: central_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 255, max consecutive WAIT cycles without arith_finish before error (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of op_count.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port go  input  1  execute-one-instruction request, sampled only in IDLE.
REQ-006 SHALL have port instr_op  input  3  operation code, sampled with go.
REQ-007 SHALL have port instr_fetch  input  1  operand memory read needed, sampled with go.
REQ-008 SHALL have port abort  input  1  synchronous return to IDLE.
REQ-009 SHALL have port mem_req  output  1  memory read request, level.
REQ-010 SHALL have port mem_ack  input  1  memory data ready, single-cycle pulse.
REQ-011 SHALL have port do_read_mem  output  1  one-cycle pulse loading memory data into datapath.
REQ-012 SHALL have port arith_start  output  1  one-cycle start pulse to arithmetic controller.
REQ-013 SHALL have port arith_op  output  3  latched operation code.
REQ-014 SHALL have port arith_finish  input  1  arithmetic controller completion pulse.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle instruction-complete pulse.
REQ-017 SHALL have port err  output  1  watchdog error flag, held in ERR.
REQ-018 SHALL have port op_count  output  CNT_W  completed-instruction count.

Function
REQ-019 SHALL implement states IDLE, MEM, LOAD, START, WAIT, DONE, ERR; all outputs decoded from registered state (Moore).
REQ-020 IDLE: go=1 and instr_op != OP_NULL (3'd0, const.vh) -> latch instr_op into arith_op; next MEM if instr_fetch=1, else START.
REQ-021 IDLE: go=1 with instr_op == OP_NULL SHALL be ignored (stay IDLE, no latch).
REQ-022 MEM: mem_req=1; mem_ack=1 -> LOAD; otherwise stay MEM indefinitely (no watchdog).
REQ-023 LOAD: do_read_mem=1 for exactly this cycle; next START.
REQ-024 START: arith_start=1 for exactly this cycle; watchdog counter cleared to 0; next WAIT.
REQ-025 WAIT: arith_finish=1 -> DONE; else counter increments; finish=0 with counter == WDOG_LIMIT-1 -> ERR.
REQ-026 arith_finish coincident with watchdog limit SHALL win (-> DONE).
REQ-027 DONE: done=1 for this cycle; op_count increments, wraps from all-ones to 0; next IDLE.
REQ-028 ERR: err=1; stays ERR until abort or reset; go ignored.
REQ-029 abort=1 in any state SHALL force IDLE next cycle, highest priority over all transitions; op_count unchanged; no done pulse.
REQ-030 arith_op SHALL hold latched value until next accepted go; not cleared by DONE, ERR or abort.
REQ-031 mem_ack outside MEM and arith_finish outside WAIT SHALL be ignored.
REQ-032 go outside IDLE (including the DONE cycle) SHALL be ignored; not queued.
REQ-033 Latency without fetch: go accepted cycle 0 -> arith_start cycle 1 -> WAIT from cycle 2; finish in cycle k -> done in cycle k+1 -> IDLE cycle k+2.
REQ-034 Fetch path SHALL add MEM cycles until ack plus one LOAD cycle before START.

Reset
REQ-035 resetn=0 SHALL asynchronously force IDLE, arith_op=3'd0, op_count=0, watchdog=0.
REQ-036 During reset, all outputs SHALL be 0: mem_req, do_read_mem, arith_start, busy, done, err.
REQ-037 Reset mid-operation (any state) SHALL abandon the instruction with no done pulse; first go after release SHALL be accepted normally.

Verification
REQ-038 go, instr_op=3'd5, instr_fetch=0; finish 3 cycles after start -> arith_start cycle 1, arith_op=5, done one cycle after finish, op_count 0->1.
REQ-039 instr_fetch=1, mem_ack 4 cycles later -> mem_req high 4 cycles, do_read_mem one pulse next cycle, arith_start following cycle.
REQ-040 WDOG_LIMIT=8, never finish -> ERR after 8 WAIT cycles, err held; abort -> IDLE, err=0, op_count unchanged.
REQ-041 finish on exactly the 8th WAIT cycle (WDOG_LIMIT=8) -> DONE, err stays 0.
REQ-042 op_count preset to all-ones via 2^CNT_W-1 instructions (CNT_W=4: 15), one more -> op_count=0.
REQ-043 resetn asserted in WAIT, go with OP_NULL, go during DONE -> immediate IDLE/all outputs 0, no acceptance, no queued execution.
